// File: rtl/ball_engine.sv
// ball_engine: moves one ball diagonally over a ROWS x COLS occupancy grid, reflecting off
// edges and occupied cells, and reports brick hits and ball loss as one-cycle pulses.
module ball_engine #(
  parameter int ROWS           = 12,
  parameter int COLS           = 16,
  parameter int RW             = 4,
  parameter int CW             = 4,
  parameter int PW             = 16,
  parameter int LOSE_AT_BOTTOM = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] data,
  input  logic                 launch,
  input  logic [CW-1:0]        launch_col,
  input  logic [PW-1:0]        step_period,
  input  logic                 pause,
  output logic [RW-1:0]        ball_row,
  output logic [CW-1:0]        ball_col,
  output logic [1:0]           ball_dir,
  output logic [1:0]           state,
  output logic                 hit_valid,
  output logic [RW-1:0]        hit_row,
  output logic [CW-1:0]        hit_col,
  output logic                 lost
);
  localparam int IW = $clog2(ROWS*COLS);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_MOVING = 2'b01, ST_LOST = 2'b10} state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  logic [1:0]    dir_reg, dir_next;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic          hit_valid_reg, hit_valid_next;
  logic [RW-1:0] hit_row_reg, hit_row_next;
  logic [CW-1:0] hit_col_reg, hit_col_next;
  logic          lost_reg, lost_next;

  function automatic logic in_grid(input int r, input int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

  function automatic logic brick(input int r, input int c);
    logic b;
    b = 1'b0;
    if (in_grid(r, c)) b = data[IW'(r*COLS + c)];
    return b;
  endfunction

  // Reflection view: off-grid is solid, except the open floor in lose-at-bottom mode.
  function automatic logic wall(input int r, input int c);
    logic w;
    if (in_grid(r, c))                          w = brick(r, c);
    else if ((LOSE_AT_BOTTOM != 0) && (r >= ROWS)) w = 1'b0;
    else                                        w = 1'b1;
    return w;
  endfunction

  int            r, c, dr, dc, ndr, ndc;
  logic          v_occ, h_occ, d_occ;
  logic [1:0]    step_dir;
  logic          step_move, hit_found;
  logic [RW-1:0] step_row, hit_r;
  logic [CW-1:0] step_col, hit_c;

  always_comb begin
    r     = int'(row_reg);
    c     = int'(col_reg);
    dr    = dir_reg[1] ? 1 : -1;
    dc    = dir_reg[0] ? 1 : -1;
    v_occ = wall(r + dr, c);
    h_occ = wall(r, c + dc);
    d_occ = wall(r + dr, c + dc);
    ndr   = dr;
    ndc   = dc;
    if (v_occ && !h_occ) begin
      ndr = -dr;
      if (wall(r - dr, c + dc)) ndc = -dc;
    end else if (h_occ && !v_occ) begin
      ndc = -dc;
      if (wall(r + dr, c - dc)) ndr = -dr;
    end else if (v_occ || d_occ) begin
      ndr = -dr;
      ndc = -dc;
    end
    step_dir  = {ndr > 0, ndc > 0};
    step_move = in_grid(r + ndr, c + ndc) && !brick(r + ndr, c + ndc);
    step_row  = RW'(r + ndr);
    step_col  = CW'(c + ndc);
    // Only bricks that caused the primary bounce count; V outranks H outranks D.
    hit_found = 1'b0;
    hit_r     = '0;
    hit_c     = '0;
    if (brick(r + dr, c)) begin
      hit_found = 1'b1;
      hit_r     = RW'(r + dr);
      hit_c     = CW'(c);
    end else if (brick(r, c + dc)) begin
      hit_found = 1'b1;
      hit_r     = RW'(r);
      hit_c     = CW'(c + dc);
    end else if (!v_occ && !h_occ && brick(r + dr, c + dc)) begin
      hit_found = 1'b1;
      hit_r     = RW'(r + dr);
      hit_c     = CW'(c + dc);
    end
  end

  logic [PW-1:0] max_cnt;
  logic          lose_now;
  logic [CW-1:0] launch_clamped;

  assign max_cnt        = (step_period == '0) ? '0 : step_period - PW'(1);
  assign lose_now       = (LOSE_AT_BOTTOM != 0) && (int'(row_reg) == ROWS - 1) && dir_reg[1];
  assign launch_clamped = (int'(launch_col) >= COLS) ? CW'(COLS - 1) : launch_col;

  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    dir_next       = dir_reg;
    cnt_next       = cnt_reg;
    hit_valid_next = 1'b0;
    hit_row_next   = hit_row_reg;
    hit_col_next   = hit_col_reg;
    lost_next      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_LOST: begin
        if (launch) begin
          state_next = ST_MOVING;
          row_next   = RW'(ROWS - 3);
          col_next   = launch_clamped;
          dir_next   = 2'b00;
          cnt_next   = '0;
        end
      end
      ST_MOVING: begin
        if (!pause) begin
          // >= rather than == so a shortened period fires immediately instead of wrapping.
          if (cnt_reg >= max_cnt) begin
            cnt_next = '0;
            if (lose_now) begin
              state_next = ST_LOST;
              lost_next  = 1'b1;
            end else begin
              dir_next = step_dir;
              if (step_move) begin
                row_next = step_row;
                col_next = step_col;
              end
              if (hit_found) begin
                hit_valid_next = 1'b1;
                hit_row_next   = hit_r;
                hit_col_next   = hit_c;
              end
            end
          end else begin
            cnt_next = cnt_reg + PW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      row_reg       <= RW'(ROWS - 3);
      col_reg       <= CW'(COLS/2 - 1);
      dir_reg       <= 2'b00;
      cnt_reg       <= '0;
      hit_valid_reg <= 1'b0;
      hit_row_reg   <= '0;
      hit_col_reg   <= '0;
      lost_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      dir_reg       <= dir_next;
      cnt_reg       <= cnt_next;
      hit_valid_reg <= hit_valid_next;
      hit_row_reg   <= hit_row_next;
      hit_col_reg   <= hit_col_next;
      lost_reg      <= lost_next;
    end
  end

  assign ball_row  = row_reg;
  assign ball_col  = col_reg;
  assign ball_dir  = dir_reg;
  assign state     = state_reg;
  assign hit_valid = hit_valid_reg;
  assign hit_row   = hit_row_reg;
  assign hit_col   = hit_col_reg;
  assign lost      = lost_reg;
endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a reflecting-floor instance (A) and a lose-at-bottom
// instance (B); each observed output change or pulse is matched against queued expectations.
module tb_ball_engine;
  localparam int ROWS = 12;
  localparam int COLS = 16;
  localparam int RW   = 4;
  localparam int CW   = 5;
  localparam int PW   = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [ROWS*COLS-1:0] data;
  logic                 launch_a, launch_b;
  logic [CW-1:0]        launch_col;
  logic [PW-1:0]        step_period;
  logic                 pause;

  logic [RW-1:0] a_row, b_row, a_hr, b_hr;
  logic [CW-1:0] a_col, b_col, a_hc, b_hc;
  logic [1:0]    a_dir, b_dir, a_state, b_state;
  logic          a_hv, b_hv, a_lost, b_lost;

  ball_engine #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW), .PW(PW), .LOSE_AT_BOTTOM(0)) dut_a (
    .clock(clock), .reset(reset), .data(data), .launch(launch_a), .launch_col(launch_col),
    .step_period(step_period), .pause(pause), .ball_row(a_row), .ball_col(a_col),
    .ball_dir(a_dir), .state(a_state), .hit_valid(a_hv), .hit_row(a_hr), .hit_col(a_hc),
    .lost(a_lost));

  ball_engine #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW), .PW(PW), .LOSE_AT_BOTTOM(1)) dut_b (
    .clock(clock), .reset(reset), .data(data), .launch(launch_b), .launch_col(launch_col),
    .step_period(step_period), .pause(pause), .ball_row(b_row), .ball_col(b_col),
    .ball_dir(b_dir), .state(b_state), .hit_valid(b_hv), .hit_row(b_hr), .hit_col(b_hc),
    .lost(b_lost));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [1:0]    dir;
    logic [1:0]    st;
    logic          hv;
    logic [RW-1:0] hr;
    logic [CW-1:0] hc;
    logic          lost;
    logic [15:0]   gap;   // clocks since previous event; 0 = not checked
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push(input int which, input int row, input int col, input int dir,
                      input int st, input int hv, input int hr, input int hc,
                      input int lost, input int gap);
    ev_t e;
    e.row  = RW'(row);
    e.col  = CW'(col);
    e.dir  = 2'(dir);
    e.st   = 2'(st);
    e.hv   = 1'(hv);
    e.hr   = RW'(hr);
    e.hc   = CW'(hc);
    e.lost = 1'(lost);
    e.gap  = 16'(gap);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // Hand-derived free-flight path from (9,7) heading up-left on an empty grid, period 1.
  task automatic push_path(input int which, input int nsteps);
    for (int k = 1; k <= nsteps; k++) begin
      if (k <= 7)       push(which, 9 - k, 7 - k, 0, 1, 0, 0, 0, 0, 1);
      else if (k == 8)  push(which, 1, 1, 1, 1, 0, 0, 0, 0, 1);
      else if (k == 9)  push(which, 0, 2, 1, 1, 0, 0, 0, 0, 1);
      else              push(which, k - 9, k - 7, 3, 1, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic cmp(input string tag, input ev_t e, input logic [RW-1:0] row,
                     input logic [CW-1:0] col, input logic [1:0] dir, input logic [1:0] st,
                     input logic hv, input logic [RW-1:0] hr, input logic [CW-1:0] hc,
                     input logic lost, input int gap);
    checks++;
    if (row !== e.row || col !== e.col || dir !== e.dir || st !== e.st || hv !== e.hv ||
        hr !== e.hr || hc !== e.hc || lost !== e.lost || (e.gap != 0 && gap != int'(e.gap))) begin
      errors++;
      $display("FAIL %s_event got r=%0d c=%0d dir=%0d st=%0d hit=%0d@(%0d,%0d) lost=%0d gap=%0d required r=%0d c=%0d dir=%0d st=%0d hit=%0d@(%0d,%0d) lost=%0d gap=%0d",
               tag, row, col, dir, st, hv, hr, hc, lost, gap,
               e.row, e.col, e.dir, e.st, e.hv, e.hr, e.hc, e.lost, e.gap);
    end else begin
      $display("event %s r=%0d c=%0d dir=%0d st=%0d hit=%0d@(%0d,%0d) lost=%0d gap=%0d ok",
               tag, row, col, dir, st, hv, hr, hc, lost, gap);
    end
  endtask

  int   cyc_a = 0, last_a = 0, cyc_b = 0, last_b = 0;
  logic [21:0] prev_a = '1;
  logic [21:0] prev_b = '1;

  always @(negedge clock) begin : mon_a
    logic [21:0] cur;
    ev_t         e;
    cur = {a_row, a_col, a_dir, a_state, a_hr, a_hc};
    cyc_a++;
    if (cur !== prev_a || a_hv === 1'b1 || a_lost === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL A_unexpected got r=%0d c=%0d dir=%0d st=%0d hit=%0d lost=%0d required no event",
                 a_row, a_col, a_dir, a_state, a_hv, a_lost);
      end else begin
        e = qa.pop_front();
        cmp("A", e, a_row, a_col, a_dir, a_state, a_hv, a_hr, a_hc, a_lost, cyc_a - last_a);
      end
      prev_a = cur;
      last_a = cyc_a;
    end
  end

  always @(negedge clock) begin : mon_b
    logic [21:0] cur;
    ev_t         e;
    cur = {b_row, b_col, b_dir, b_state, b_hr, b_hc};
    cyc_b++;
    if (cur !== prev_b || b_hv === 1'b1 || b_lost === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL B_unexpected got r=%0d c=%0d dir=%0d st=%0d hit=%0d lost=%0d required no event",
                 b_row, b_col, b_dir, b_state, b_hv, b_lost);
      end else begin
        e = qb.pop_front();
        cmp("B", e, b_row, b_col, b_dir, b_state, b_hv, b_hr, b_hc, b_lost, cyc_b - last_b);
      end
      prev_b = cur;
      last_b = cyc_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic launch_pulse(input int which, input int col);
    launch_col = CW'(col);
    if (which == 0) launch_a = 1'b1;
    else            launch_b = 1'b1;
    @(posedge clock);
    #1;
    launch_a = 1'b0;
    launch_b = 1'b0;
  endtask

  // Asserts reset between a sample point and the next edge; outputs must drop at once.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (a_state !== 2'b00 || a_row !== 4'd9 || a_col !== 5'd7 || a_dir !== 2'b00 || a_hv !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got st=%0d r=%0d c=%0d dir=%0d hit=%0d required st=0 r=9 c=7 dir=0 hit=0",
               a_state, a_row, a_col, a_dir, a_hv);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic drained(input string name);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got pending A=%0d B=%0d required 0 0", name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    data        = '0;
    launch_a    = 1'b0;
    launch_b    = 1'b0;
    launch_col  = 5'd7;
    step_period = 16'd1;
    pause       = 1'b0;
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    push(1, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    tick(3);
    reset = 1'b1;
    tick(2);
    drained("reset");

    // Free flight, corner bounce at the left wall and top edge.
    push(0, 9, 7, 0, 1, 0, 0, 0, 0, 0);
    push_path(0, 10);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 7);
    tick(10);
    do_reset();
    tick(2);
    drained("path");

    // Lone diagonal brick: bounce back, hit reported, then held on the next step.
    data = '0;
    data[134] = 1'b1;
    step_period = 16'd8;
    push(0, 9, 7, 0, 1, 0, 0, 0, 0, 0);
    push(0, 10, 8, 3, 1, 1, 8, 6, 0, 8);
    push(0, 11, 9, 3, 1, 0, 8, 6, 0, 8);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 7);
    tick(16);
    do_reset();
    tick(2);
    drained("diag_hit");

    // Blocked reverse target: stall in place with the new direction.
    data = '0;
    data[135] = 1'b1;
    data[150] = 1'b1;
    data[168] = 1'b1;
    push(0, 9, 7, 0, 1, 0, 0, 0, 0, 0);
    push(0, 9, 7, 3, 1, 1, 8, 7, 0, 8);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 7);
    tick(8);
    do_reset();
    tick(2);
    drained("stall");

    // Period 4, clamped launch column, pause for 10 clocks, launch ignored while moving.
    data = '0;
    step_period = 16'd4;
    push(0, 9, 15, 0, 1, 0, 0, 0, 0, 0);
    push(0, 8, 14, 0, 1, 0, 0, 0, 0, 4);
    push(0, 7, 13, 0, 1, 0, 0, 0, 0, 4);
    push(0, 6, 12, 0, 1, 0, 0, 0, 0, 14);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 20);
    tick(8);
    pause = 1'b1;
    tick(3);
    launch_col = 5'd3;
    launch_a = 1'b1;
    tick(1);
    launch_a = 1'b0;
    tick(6);
    pause = 1'b0;
    tick(4);
    do_reset();
    tick(2);
    drained("period_pause");

    step_period = 16'd1;
    push(0, 9, 15, 0, 1, 0, 0, 0, 0, 0);
    push(0, 8, 14, 0, 1, 0, 0, 0, 0, 1);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 15);
    tick(1);
    do_reset();
    tick(2);
    drained("col15");

    // Reset mid-flight at (4,2), then a fresh launch behaves as from power-up.
    push(0, 9, 7, 0, 1, 0, 0, 0, 0, 0);
    push_path(0, 5);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 7);
    tick(5);
    do_reset();
    tick(2);
    drained("midflight");
    push(0, 9, 7, 0, 1, 0, 0, 0, 0, 0);
    push_path(0, 2);
    push(0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
    launch_pulse(0, 7);
    tick(2);
    do_reset();
    tick(2);
    drained("relaunch");

    // Lose-at-bottom: 20 steps to (11,13), the 21st ends play; relaunch from LOST.
    push(1, 9, 7, 0, 1, 0, 0, 0, 0, 0);
    push_path(1, 20);
    push(1, 11, 13, 3, 2, 0, 0, 0, 1, 1);
    launch_pulse(1, 7);
    tick(21);
    tick(5);
    drained("lost");
    step_period = 16'd1000;
    push(1, 9, 15, 0, 1, 0, 0, 0, 0, 0);
    launch_pulse(1, 20);
    tick(3);
    drained("lost_relaunch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
